// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and status counter width.
package pll_seq_pkg;

  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    PllReset  = 2'd0,
    WaitLock  = 2'd1,
    Stabilise = 2'd2,
    Running   = 2'd3
  } pll_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-facing and status signals of the reset sequencer; master is the sequencer side.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic              pll_locked;
  logic              pll_rst;
  logic              locked;
  logic              sys_rst;
  logic              lock_lost;
  logic [STAT_W-1:0] relock_count;
  logic [STAT_W-1:0] timeout_count;

  modport master (
    input  pll_locked,
    output pll_rst, locked, sys_rst, lock_lost, relock_count, timeout_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, locked, sys_rst, lock_lost, relock_count, timeout_count
  );

endinterface

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with synchronous active-high clear.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-wait / stabilise sequencer producing a clean lock flag and system reset.
// Status counters are built only when PLL_RESET_SEQUENCER_COUNTERS_EN is defined.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned CNT_W               = 20
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master seq_if
);

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  pll_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lock_lost_q;
  logic             locked_s;
  logic             timeout_hit;
  logic             lock_loss;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .refclk(refclk),
    .rst   (rst),
    .d     (seq_if.pll_locked),
    .q     (locked_s)
  );

  // Lock takes priority over a coincident timeout compare.
  assign timeout_hit = (state_q == WaitLock) && !locked_s && (cnt_q == TimeoutLast);
  assign lock_loss   = (state_q == Running) && !locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PllReset;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= lock_loss;
      unique case (state_q)
        PllReset: begin
          if (cnt_q == RstLast) begin
            state_q <= WaitLock;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WaitLock: begin
          if (locked_s) begin
            state_q <= Stabilise;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            state_q <= PllReset;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        Stabilise: begin
          // A glitch only restarts the lock wait; the PLL is not reset.
          if (!locked_s) begin
            state_q <= WaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q <= Running;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        Running: begin
          if (lock_loss) begin
            state_q <= PllReset;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign seq_if.pll_rst   = (state_q == PllReset);
  assign seq_if.locked    = (state_q == Running);
  assign seq_if.sys_rst   = (state_q != Running);
  assign seq_if.lock_lost = lock_lost_q;

`ifdef PLL_RESET_SEQUENCER_COUNTERS_EN
  logic [STAT_W-1:0] relock_q;
  logic [STAT_W-1:0] timeout_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      relock_q  <= '0;
      timeout_q <= '0;
    end else begin
      if (lock_loss)   relock_q  <= sat_inc(relock_q);
      if (timeout_hit) timeout_q <= sat_inc(timeout_q);
    end
  end

  assign seq_if.relock_count  = relock_q;
  assign seq_if.timeout_count = timeout_q;
`else
  assign seq_if.relock_count  = '0;
  assign seq_if.timeout_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; expected status counts follow
// PLL_RESET_SEQUENCER_COUNTERS_EN (zero when it is undefined).
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQUENCER_COUNTERS_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .SYNC_STAGES        (2),
    .CNT_W              (20)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .seq_if(bus)
  );

  always #5 refclk = ~refclk;

  // Advance one edge; inputs set afterwards are sampled by the next edge.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
    return CntEn ? 8'(n) : 8'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    step();
    step();
    vectors++;
    if ({bus.pll_rst, bus.sys_rst, bus.locked, bus.lock_lost} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 1100",
               {bus.pll_rst, bus.sys_rst, bus.locked, bus.lock_lost});
    end
    vectors++;
    if ({bus.relock_count, bus.timeout_count} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_counts: got %h expected 0000", {bus.relock_count, bus.timeout_count});
    end
  endtask

  task automatic test_startup();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (bus.pll_rst !== (k < 4)) begin
        miscompares++;
        $display("FAIL startup_pll_rst k=%0d: got %b expected %b", k, bus.pll_rst, k < 4);
      end
    end
    repeat (6) step();
    bus.pll_locked = 1'b1;
    // The first edge after this is cycle 0; RUNNING is reached on its 11th edge.
    for (int i = 1; i <= 11; i++) begin
      step();
      vectors++;
      if (bus.sys_rst !== (i < 11) || bus.locked !== (i == 11)) begin
        miscompares++;
        $display("FAIL startup_release i=%0d: got sys_rst=%b locked=%b expected %b %b",
                 i, bus.sys_rst, bus.locked, i < 11, i == 11);
      end
    end
    vectors++;
    if ({bus.relock_count, bus.timeout_count, bus.lock_lost} !== 17'h0) begin
      miscompares++;
      $display("FAIL startup_counts: got %h/%h/%b expected 0/0/0",
               bus.relock_count, bus.timeout_count, bus.lock_lost);
    end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    step();
    rst = 1'b0;
    // 4 cycles of pll_rst then 32 of WAIT_LOCK: period 36.
    for (int k = 1; k <= 112; k++) begin
      step();
      vectors++;
      if (bus.pll_rst !== ((k % 36) < 4) || bus.sys_rst !== 1'b1 ||
          bus.timeout_count !== exp_cnt(k / 36)) begin
        miscompares++;
        $display("FAIL timeout k=%0d: got pll_rst=%b sys_rst=%b tcnt=%0d expected %b 1 %0d",
                 k, bus.pll_rst, bus.sys_rst, bus.timeout_count, (k % 36) < 4,
                 exp_cnt(k / 36));
      end
    end
  endtask

  task automatic test_glitch();
    // Lock high 5 cycles, low 1, then high; re-sampled lock is the 7th edge.
    for (int n = 1; n <= 17; n++) begin
      bus.pll_locked = (n != 6);
      step();
      vectors++;
      if (bus.pll_rst !== 1'b0 || bus.sys_rst !== (n < 17)) begin
        miscompares++;
        $display("FAIL glitch n=%0d: got pll_rst=%b sys_rst=%b expected 0 %b",
                 n, bus.pll_rst, bus.sys_rst, n < 17);
      end
    end
    vectors++;
    if (bus.timeout_count !== exp_cnt(3) || bus.relock_count !== 8'd0) begin
      miscompares++;
      $display("FAIL glitch_counts: got tcnt=%0d rcnt=%0d expected %0d 0",
               bus.timeout_count, bus.relock_count, exp_cnt(3));
    end
  endtask

  task automatic test_lock_loss();
    logic exp_sys;
    for (int n = 1; n <= 16; n++) begin
      bus.pll_locked = (n != 1);
      step();
      exp_sys = (n >= 3 && n <= 15);
      vectors++;
      if (bus.sys_rst !== exp_sys || bus.locked !== !exp_sys ||
          bus.lock_lost !== (n == 3) || bus.pll_rst !== (n >= 3 && n <= 6)) begin
        miscompares++;
        $display("FAIL lock_loss n=%0d: got sys=%b lk=%b lost=%b prst=%b expected %b %b %b %b",
                 n, bus.sys_rst, bus.locked, bus.lock_lost, bus.pll_rst,
                 exp_sys, !exp_sys, n == 3, n >= 3 && n <= 6);
      end
    end
    vectors++;
    if (bus.relock_count !== exp_cnt(1) || bus.timeout_count !== exp_cnt(3)) begin
      miscompares++;
      $display("FAIL lock_loss_counts: got rcnt=%0d tcnt=%0d expected %0d %0d",
               bus.relock_count, bus.timeout_count, exp_cnt(1), exp_cnt(3));
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 300 * 36 + 4; k++) begin
      step();
      if (k == 255 * 36 - 1 || k == 255 * 36) begin
        vectors++;
        if (bus.timeout_count !== exp_cnt(k / 36)) begin
          miscompares++;
          $display("FAIL sat_edge k=%0d: got %0d expected %0d", k, bus.timeout_count,
                   exp_cnt(k / 36));
        end
      end
    end
    vectors++;
    if (bus.timeout_count !== exp_cnt(255) || bus.sys_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_final: got tcnt=%0d sys_rst=%b expected %0d 1",
               bus.timeout_count, bus.sys_rst, exp_cnt(255));
    end
  endtask

  task automatic test_mid_rst();
    bus.pll_locked = 1'b1;
    repeat (5) step();
    vectors++;
    if (bus.pll_rst !== 1'b0 || bus.sys_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_rst_pre: got pll_rst=%b sys_rst=%b expected 0 1",
               bus.pll_rst, bus.sys_rst);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({bus.pll_rst, bus.sys_rst, bus.locked, bus.lock_lost} !== 4'b1100 ||
        {bus.relock_count, bus.timeout_count} !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_rst: got %b %h expected 1100 0000",
               {bus.pll_rst, bus.sys_rst, bus.locked, bus.lock_lost},
               {bus.relock_count, bus.timeout_count});
    end
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      vectors++;
      if (bus.pll_rst !== (k < 4) || bus.sys_rst !== (k < 13)) begin
        miscompares++;
        $display("FAIL restart k=%0d: got pll_rst=%b sys_rst=%b expected %b %b",
                 k, bus.pll_rst, bus.sys_rst, k < 4, k < 13);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_saturation();
    test_mid_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the MMCM wrappers (pll_base, pll_sgmii_tx/rx) on the same refclk. Drives the PLL's rst and consumes its asynchronous locked output. Sequences PLL reset, lock wait with timeout/retry and lock stabilisation. Emits a clean stable-lock flag and a system reset that downstream clock-domain reset synchronisers consume.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles to wait for lock before re-resetting the PLL (>=2)
LOCK_STABLE_CYCLES, 1024, cycles lock must be continuously high before release (>=1)
SYNC_STAGES, 2, flops in the pll_locked synchroniser (>=2)
CNT_W, 20, width of the shared phase counter; must hold max of the three cycle parameters

Ports:
refclk  in  1  clock; the same reference clock fed to the PLL
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL LOCKED, asynchronous to refclk
pll_rst  out  1  to PLL rst
locked  out  1  stable lock, high only in RUNNING
sys_rst  out  1  active-high system reset, low only in RUNNING
lock_lost  out  1  one-cycle pulse on loss of lock from RUNNING
relock_count  out  8  saturating count of lock losses from RUNNING
timeout_count  out  8  saturating count of lock-wait timeouts

Behaviour:
- Interface: one clock, refclk; reset rst is synchronous and active-high.
- rst high at an edge: state=PLL_RESET, counter=0, synchroniser flops=0, relock_count=0, timeout_count=0, lock_lost=0. Outputs are pll_rst=1, sys_rst=1, locked=0 from the next cycle.
- pll_rst, sys_rst and locked decode from the state register only, with no combinational path from pll_locked. lock_lost is a registered pulse.
- locked_s is pll_locked after SYNC_STAGES flops.
- PLL_RESET: pll_rst=1. counter++ each cycle. When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK and clear counter. pll_rst is high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1: go to STABILISE, counter=0.
  - Else counter++. At counter==LOCK_TIMEOUT_CYCLES-1, go to PLL_RESET, counter=0, timeout_count+1 (saturates at 255).
- STABILISE: pll_rst=0.
  - If locked_s=0 (glitch): return to WAIT_LOCK, counter=0, no PLL reset, no count.
  - Else counter++. At counter==LOCK_STABLE_CYCLES-1, go to RUNNING.
- RUNNING: sys_rst=0, locked=1.
  - If locked_s=0: go to PLL_RESET, counter=0.
  - lock_lost=1 for the following cycle. relock_count+1 (saturates at 255).
- Latency: let cycle 0 be the first edge sampling pll_locked=1 in WAIT_LOCK, with lock then held. STABILISE starts at cycle SYNC_STAGES+1. sys_rst falls at cycle SYNC_STAGES+1+LOCK_STABLE_CYCLES (1027 at defaults).
- Loss of lock: sys_rst rises SYNC_STAGES+1 cycles after pll_locked falls.
- Simultaneous events:
  - rst has priority over everything.
  - The timeout compare and locked_s=1 in the same cycle: lock wins and no timeout is counted.
- rst mid-sequence (any state) restarts the full sequence. Counters are cleared.

Optional Feature:
Macro PLL_RESET_SEQUENCER_COUNTERS_EN.
- Defined: relock_count and timeout_count behave as above.
- Undefined: both are tied to 8'd0 and their registers are not built. lock_lost and the FSM are unchanged.

Decomposition:
- Package pll_seq_pkg holds:
  - a 2-bit state typedef (PLL_RESET=0, WAIT_LOCK=1, STABILISE=2, RUNNING=3);
  - the STAT_W=8 status counter width constant.
- One natural sub-module: sync_bit (parameter SYNC_STAGES, ports refclk/rst/d/q), the pll_locked synchroniser. It is reused by downstream reset synchronisers.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2.
1. Reset, then pll_locked rises 10 cycles after rst falls -> pll_rst high exactly 4 cycles; sys_rst falls 11 cycles after the first sampled lock; locked=1; counts=0.
2. pll_locked held low -> pll_rst re-pulses (4 cycles) every 36 cycles; timeout_count increments 1,2,3...; sys_rst stays 1.
3. pll_locked high for 5 cycles in STABILISE, low for 1, then high -> return to WAIT_LOCK; no pll_rst pulse; sys_rst falls 11 cycles after the re-sampled lock; timeout_count unchanged.
4. In RUNNING, drop pll_locked for 1 cycle -> sys_rst=1 three cycles later; single lock_lost pulse; relock_count=1; pll_rst 4-cycle pulse.
5. Force 300 timeouts -> timeout_count saturates at 255. Assert rst mid-STABILISE -> all outputs back to reset values next cycle.
6. Build without PLL_RESET_SEQUENCER_COUNTERS_EN, rerun 2 and 4 -> counts read 0; FSM timing identical.
